// File: rtl/cpa_iter_pkg.sv
// ============================================================================
// Module  : cpa_pkg
// Brief   : Shared state encoding and sizing helpers for the iterative CPA.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_nchunk(input int dw, input int cw);
        return dw / cw;
    endfunction

    // Counter width for n chunks, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpa_iter_if.sv
// ============================================================================
// Module  : cpa_iter_if
// Brief   : Operand/result handshake bundle for the iterative CPA.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface cpa_iter_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_s;
    logic [DW-1:0] in_c;
    logic          out_valid;
    logic          out_ready;
    logic [DW+1:0] result;

    modport master (
        output in_valid, in_s, in_c, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, in_s, in_c, out_ready,
        output in_ready, out_valid, result
    );
endinterface

`default_nettype wire

// File: rtl/cpa_iter_chunk_add.sv
// ============================================================================
// Module  : cpa_chunk_add
// Brief   : Combinational CW-bit adder with carry-in and carry-out.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cpa_chunk_add #(
    parameter int CW = 8
) (
    input  wire logic [CW-1:0] a,
    input  wire logic [CW-1:0] b,
    input  wire logic          cin,
    output logic      [CW-1:0] sum,
    output logic               cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
endmodule

`default_nettype wire

// File: rtl/cpa_iter.sv
// ============================================================================
// Module  : cpa_iter
// Brief   : Iterative carry-propagate adder resolving s + 2*c, CW bits/cycle.
//           Optional zero-detect early exit under macro CPA_EARLY_EXIT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cpa_iter #(
    parameter int DW = 32,
    parameter int CW = 8
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    cpa_iter_if.slave   bus
);
    import cpa_pkg::*;

    localparam int c_nchunk = calc_nchunk(DW, CW);
    localparam int c_cntw   = cnt_width(c_nchunk);
    localparam logic [c_cntw-1:0] c_last_k = c_cntw'(c_nchunk - 1);

    if (DW % CW != 0) begin : g_dw_check
        $error("cpa_iter: DW must be a multiple of CW");
    end

    state_t              r_state;
    logic [DW-1:0]       r_a;
    logic [DW-1:0]       r_b;
    logic                r_ctop;
    logic                r_carry;
    logic [c_cntw-1:0]   r_k;
    logic [DW+1:0]       r_result;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [CW-1:0]       w_a_chunk;
    logic [CW-1:0]       w_b_chunk;
    logic [CW-1:0]       w_sum;
    logic                w_cout;
    logic                w_early;

    assign w_a_chunk = CW'(r_a >> (r_k * CW));
    assign w_b_chunk = CW'(r_b >> (r_k * CW));

    cpa_chunk_add #(.CW(CW)) u_chunk_add (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

`ifdef CPA_EARLY_EXIT_EN
    // Finish once nothing above the current chunk can change the result.
    logic [DW-1:0] w_a_hi;
    logic [DW-1:0] w_b_hi;
    always_comb begin
        w_a_hi  = r_a >> ((int'(r_k) + 1) * CW);
        w_b_hi  = r_b >> ((int'(r_k) + 1) * CW);
        w_early = (w_a_hi == '0) && (w_b_hi == '0) && !w_cout && !r_ctop;
    end
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_ctop      <= 1'b0;
            r_carry     <= 1'b0;
            r_k         <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.in_s;
                        r_b        <= {bus.in_c[DW-2:0], 1'b0};
                        r_ctop     <= bus.in_c[DW-1];
                        r_carry    <= 1'b0;
                        r_k        <= '0;
                        r_result   <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ADD;
                    end
                end
                ADD: begin
                    r_result[r_k*CW +: CW] <= w_sum;
                    r_carry                <= w_cout;
                    r_k                    <= r_k + c_cntw'(1);
                    if (r_k == c_last_k || w_early) begin
                        r_result[DW+1:DW] <= {1'b0, r_ctop} + {1'b0, w_cout};
                        r_out_valid       <= 1'b1;
                        r_state           <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

endmodule

`default_nettype wire

// File: tb/tb_cpa_iter.sv
// ============================================================================
// Module  : tb_cpa_iter
// Brief   : Self-checking bench for cpa_iter against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpa_iter;
    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NCH = DW / CW;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    cpa_iter_if #(.DW(DW)) bus ();

    cpa_iter #(.DW(DW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Edges from accept to out_valid, derived from operand values alone.
    function automatic int exp_latency(input logic [31:0] s, input logic [31:0] c);
`ifdef CPA_EARLY_EXIT_EN
        longint unsigned a, b, m, lo;
        int lb;
        a = longint'(s);
        b = (longint'(c) << 1) & 64'hFFFF_FFFF;
        for (int k = 0; k < NCH; k++) begin
            lb = (k + 1) * CW;
            m  = (64'd1 << lb) - 1;
            lo = (a & m) + (b & m);
            if ((a >> lb) == 0 && (b >> lb) == 0 && lo <= m && c[31] == 1'b0)
                return k + 1;
        end
        return NCH;
`else
        return NCH;
`endif
    endfunction

    task automatic run_txn(input logic [31:0] s, input logic [31:0] c, input int hold);
        logic [63:0] exp_r;
        logic [63:0] held;
        int          exp_l;
        int          n;
        exp_r = 64'(s) + 64'(c) * 2;
        exp_l = exp_latency(s, c);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.in_s     = s;
        bus.in_c     = c;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_s     = $urandom;
        bus.in_c     = $urandom;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            check_eq("in_ready_busy", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
            bus.in_s = $urandom;
            bus.in_c = $urandom;
            n++;
        end
        check_eq("latency", 64'(n), 64'(exp_l));
        check_eq("out_valid", 64'(bus.out_valid), 64'd1);
        check_eq("result", 64'(bus.result), exp_r);
        held = 64'(bus.result);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            bus.in_s     = $urandom;
            bus.in_c     = $urandom;
            bus.in_valid = 1'($urandom_range(0, 1));
            check_eq("bp_result", 64'(bus.result), held);
            check_eq("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check_eq("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("post_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("post_in_ready", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic reset_mid_add();
        bus.in_valid = 1'b1;
        bus.in_s     = 32'hDEAD_BEEF;
        bus.in_c     = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_result", 64'(bus.result), 64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NCH + 2; i++) begin
            @(negedge clk);
            check_eq("rst_no_pulse", 64'(bus.out_valid), 64'd0);
        end
    endtask

    initial begin
        logic [31:0] s, c;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_s      = '0;
        bus.in_c      = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_result", 64'(bus.result), 64'd0);
        check_eq("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("reset_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(32'h0000_0001, 32'h0000_0001, 0);
        run_txn(32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_txn(32'h1234_5678, 32'h0F0F_F0F0, 5);
        reset_mid_add();
        run_txn(32'h0000_0010, 32'h0000_0008, 0);
        run_txn(32'h0000_0005, 32'h0000_0000, 1);
        run_txn(32'h0000_0000, 32'h0000_0000, 0);

        for (int i = 0; i < 40; i++) begin
            s = $urandom;
            c = $urandom;
            case ($urandom_range(0, 3))
                0: begin s = s & 32'h0000_00FF; c = c & 32'h0000_007F; end
                1: begin s = s & 32'h0000_FFFF; c = c & 32'h0000_7FFF; end
                2: begin s = s & 32'h00FF_FFFF; c = c & 32'h007F_FFFF; end
                default: ;
            endcase
            run_txn(s, c, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
